// File: rtl/regfile_pkg.sv
// Shared types and defaults for the parametrised register file.
package regfile_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } clr_state_e;

  localparam int DEF_WIDTH = 10;
  localparam int DEF_NREG  = 8;

  function automatic int addr_width(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/regfile_clear_seq.sv
// Clear sequencer: on CLR, walks every register index once, one per negedge,
// and reports the index being zeroed on that edge.
module regfile_clear_seq
  import regfile_pkg::*;
#(
  parameter int NREG = DEF_NREG,
  localparam int AW  = addr_width(NREG)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          clr_i,
  output logic          busy_o,
  output logic          clr_stb_o,
  output logic [AW-1:0] clr_idx_o
);

  clr_state_e    state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;

  // State and sweep index register.
  always_ff @(negedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Next state: CLR only matters in IDLE, so a request mid-sweep never restarts it.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (clr_i) begin
          state_d = SWEEP;
          idx_d   = '0;
        end else begin
          state_d = IDLE;
          idx_d   = idx_q;
        end
      end
      SWEEP: begin
        if (idx_q == AW'(NREG - 1)) begin
          state_d = IDLE;
          idx_d   = '0;
        end else begin
          state_d = SWEEP;
          idx_d   = idx_q + AW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end

  assign busy_o    = (state_q == SWEEP);
  assign clr_stb_o = (state_q == SWEEP);
  assign clr_idx_o = idx_q;

endmodule

// File: rtl/regfile_np.sv
// NREG x WIDTH register file, one write port, NRD registered read ports,
// hardware clear sweep and write-drop pulse. REGFILE_BYPASS_EN adds same-edge forwarding.
module regfile_np
  import regfile_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NREG  = DEF_NREG,
  parameter int NRD   = 2,
  localparam int AW   = addr_width(NREG)
) (
  input  logic                 CLKb,
  input  logic                 RST,
  input  logic [WIDTH-1:0]     D,
  input  logic                 ENW,
  input  logic [AW-1:0]        WRA,
  input  logic [NRD-1:0]       ENR,
  input  logic [NRD*AW-1:0]    RDA,
  output logic [NRD*WIDTH-1:0] Q,
  input  logic                 CLR,
  output logic                 BUSY,
  output logic                 WDROP
);

  logic [WIDTH-1:0]            mem_q [NREG];
  logic [WIDTH-1:0]            mem_d [NREG];
  logic [NRD-1:0][WIDTH-1:0]   q_q, q_d;
  logic [NRD-1:0][WIDTH-1:0]   rd_val_s;
  logic [NRD-1:0][AW-1:0]      rd_addr_s;
  logic                        wdrop_q, wdrop_d;
  logic                        busy_s, clr_stb_s;
  logic [AW-1:0]               clr_idx_s;
  logic                        wr_ok_s;

  regfile_clear_seq #(
    .NREG (NREG)
  ) u_clear_seq (
    .clk_i     (CLKb),
    .rst_i     (RST),
    .clr_i     (CLR),
    .busy_o    (busy_s),
    .clr_stb_o (clr_stb_s),
    .clr_idx_o (clr_idx_s)
  );

  // A write lands only in IDLE and only when it does not collide with a clear request.
  assign wr_ok_s = ENW & ~busy_s & ~CLR;
  assign wdrop_d = ENW & ~wr_ok_s;

  // Per-entry next value: sweep clear or accepted write.
  always_comb begin
    for (int i = 0; i < NREG; i++) begin
      if (clr_stb_s && (clr_idx_s == AW'(i))) begin
        mem_d[i] = '0;
      end else if (wr_ok_s && (WRA == AW'(i))) begin
        mem_d[i] = D;
      end else begin
        mem_d[i] = mem_q[i];
      end
    end
  end

  // Read data per port, optionally forwarding this edge's write or clear.
  always_comb begin
    for (int k = 0; k < NRD; k++) begin
      rd_addr_s[k] = RDA[k*AW +: AW];
      rd_val_s[k]  = mem_q[rd_addr_s[k]];
`ifdef REGFILE_BYPASS_EN
      if (wr_ok_s && (WRA == rd_addr_s[k])) begin
        rd_val_s[k] = D;
      end else if (clr_stb_s && (clr_idx_s == rd_addr_s[k])) begin
        rd_val_s[k] = '0;
      end else begin
        rd_val_s[k] = mem_q[rd_addr_s[k]];
      end
`endif
      if (ENR[k]) begin
        q_d[k] = rd_val_s[k];
      end else begin
        q_d[k] = q_q[k];
      end
    end
  end

  // Storage, read registers and drop pulse.
  always_ff @(negedge CLKb or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < NREG; i++) begin
        mem_q[i] <= '0;
      end
      q_q     <= '0;
      wdrop_q <= 1'b0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        mem_q[i] <= mem_d[i];
      end
      q_q     <= q_d;
      wdrop_q <= wdrop_d;
    end
  end

  assign Q     = q_q;
  assign BUSY  = busy_s;
  assign WDROP = wdrop_q;

endmodule

// File: tb/tb_regfile_np.sv
// Self-checking bench for regfile_np (WIDTH=10, NREG=8, NRD=2).
module tb_regfile_np;

  logic        CLKb;
  logic        RST;
  logic [9:0]  D;
  logic        ENW;
  logic [2:0]  WRA;
  logic [1:0]  ENR;
  logic [5:0]  RDA;
  logic [19:0] Q;
  logic        CLR;
  logic        BUSY;
  logic        WDROP;

  int pass_cnt  = 0;
  int total_cnt = 0;

  // Reference model: plain array contents plus a count of sweep edges remaining.
  logic [9:0] m_mem [8];
  logic [9:0] m_q   [2];
  int         m_left;
  int         m_pos;
  logic       m_wdrop;

  regfile_np #(.WIDTH(10), .NREG(8), .NRD(2)) dut (
    .CLKb  (CLKb),
    .RST   (RST),
    .D     (D),
    .ENW   (ENW),
    .WRA   (WRA),
    .ENR   (ENR),
    .RDA   (RDA),
    .Q     (Q),
    .CLR   (CLR),
    .BUSY  (BUSY),
    .WDROP (WDROP)
  );

  initial begin
    CLKb = 1'b0;
    forever #5 CLKb = ~CLKb;
  end

  task automatic idle_in();
    ENW = 1'b0; CLR = 1'b0; ENR = 2'b00; D = 10'h000; WRA = 3'd0; RDA = 6'd0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_mem[i] = 10'h000;
    m_q[0] = 10'h000; m_q[1] = 10'h000;
    m_left = 0; m_pos = 0; m_wdrop = 1'b0;
  endtask

  task automatic model_edge();
    logic       busy;
    logic       wr_ok;
    logic [2:0] a;
    logic [9:0] v;
    busy  = (m_left > 0);
    wr_ok = ENW && !busy && !CLR;
    for (int k = 0; k < 2; k++) begin
      if (ENR[k]) begin
        a = RDA[k*3 +: 3];
        v = m_mem[a];
`ifdef REGFILE_BYPASS_EN
        if (wr_ok && WRA == a) v = D;
        if (busy && m_pos == int'(a)) v = 10'h000;
`endif
        m_q[k] = v;
      end
    end
    m_wdrop = ENW && !wr_ok;
    if (busy) begin
      m_mem[m_pos] = 10'h000;
      m_pos  = m_pos + 1;
      m_left = m_left - 1;
      if (m_left == 0) m_pos = 0;
    end else if (CLR) begin
      m_left = 8;
      m_pos  = 0;
    end
    if (wr_ok) m_mem[WRA] = D;
  endtask

  task automatic tick();
    model_edge();
    @(negedge CLKb);
    #1;
  endtask

  task automatic test_reset();
    idle_in();
    RST = 1'b0;
    #1 RST = 1'b1;
    #1;
    total_cnt++; if (Q !== 20'h00000) $display("FAIL reset_q got %h exp 00000", Q); else pass_cnt++;
    total_cnt++; if (BUSY !== 1'b0) $display("FAIL reset_busy got %b exp 0", BUSY); else pass_cnt++;
    total_cnt++; if (WDROP !== 1'b0) $display("FAIL reset_wdrop got %b exp 0", WDROP); else pass_cnt++;
    model_reset();
    @(posedge CLKb);
    RST = 1'b0;
    tick();
    total_cnt++; if (Q !== 20'h00000) $display("FAIL reset_idle_q got %h exp 00000", Q); else pass_cnt++;
  endtask

  task automatic test_write_read();
    idle_in();
    ENW = 1'b1; WRA = 3'd3; D = 10'h2A5;
    tick();
    total_cnt++; if (WDROP !== 1'b0) $display("FAIL wr_nodrop got %b exp 0", WDROP); else pass_cnt++;
    idle_in();
    ENR = 2'b01; RDA = {3'd0, 3'd3};
    tick();
    total_cnt++; if (Q[9:0] !== 10'h2A5) $display("FAIL rd_q0 got %h exp 2a5", Q[9:0]); else pass_cnt++;
    total_cnt++; if (Q[19:10] !== 10'h000) $display("FAIL rd_q1_hold got %h exp 000", Q[19:10]); else pass_cnt++;
  endtask

  task automatic test_dual_port();
    idle_in();
    ENW = 1'b1; WRA = 3'd1; D = 10'h001; tick();
    WRA = 3'd6; D = 10'h3FF; tick();
    idle_in();
    ENR = 2'b11; RDA = {3'd6, 3'd1}; tick();
    total_cnt++; if (Q[9:0] !== 10'h001) $display("FAIL dual_q0 got %h exp 001", Q[9:0]); else pass_cnt++;
    total_cnt++; if (Q[19:10] !== 10'h3FF) $display("FAIL dual_q1 got %h exp 3ff", Q[19:10]); else pass_cnt++;
    RDA = {3'd6, 3'd6}; tick();
    total_cnt++; if (Q !== {10'h3FF, 10'h3FF}) $display("FAIL same_addr got %h exp %h", Q, {10'h3FF, 10'h3FF}); else pass_cnt++;
  endtask

  task automatic test_bypass();
    logic [9:0] exp_v;
    idle_in();
    ENW = 1'b1; WRA = 3'd5; D = 10'h0AA; tick();
    ENW = 1'b1; WRA = 3'd5; D = 10'h155; ENR = 2'b10; RDA = {3'd5, 3'd0};
    tick();
`ifdef REGFILE_BYPASS_EN
    exp_v = 10'h155;
`else
    exp_v = 10'h0AA;
`endif
    total_cnt++; if (Q[19:10] !== exp_v) $display("FAIL bypass_q1 got %h exp %h", Q[19:10], exp_v); else pass_cnt++;
    idle_in();
    ENR = 2'b10; RDA = {3'd5, 3'd0}; tick();
    total_cnt++; if (Q[19:10] !== 10'h155) $display("FAIL after_wr_q1 got %h exp 155", Q[19:10]); else pass_cnt++;
  endtask

  task automatic test_clear_sweep();
    int cnt;
    idle_in();
    for (int a = 0; a < 8; a++) begin
      ENW = 1'b1; WRA = 3'(a); D = 10'($urandom_range(1, 1023)); tick();
    end
    idle_in();
    CLR = 1'b1; tick();
    CLR = 1'b0;
    cnt = 0;
    for (int c = 0; c < 20 && BUSY === 1'b1; c++) begin
      cnt++;
      ENW = (c == 2); WRA = 3'd2; D = 10'h3C3;
      tick();
      if (c == 2) begin
        total_cnt++; if (WDROP !== 1'b1) $display("FAIL busy_wdrop got %b exp 1", WDROP); else pass_cnt++;
      end
      if (c == 3) begin
        total_cnt++; if (WDROP !== 1'b0) $display("FAIL wdrop_one_cycle got %b exp 0", WDROP); else pass_cnt++;
      end
    end
    total_cnt++; if (cnt != 8) $display("FAIL busy_cycles got %0d exp 8", cnt); else pass_cnt++;
    idle_in();
    for (int a = 0; a < 8; a += 2) begin
      ENR = 2'b11; RDA = {3'(a + 1), 3'(a)}; tick();
      total_cnt++; if (Q !== 20'h00000) $display("FAIL cleared_%0d got %h exp 00000", a, Q); else pass_cnt++;
    end
  endtask

  task automatic test_clr_wr();
    idle_in();
    CLR = 1'b1; ENW = 1'b1; WRA = 3'd0; D = 10'h077; tick();
    total_cnt++; if (WDROP !== 1'b1) $display("FAIL clrwr_wdrop got %b exp 1", WDROP); else pass_cnt++;
    total_cnt++; if (BUSY !== 1'b1) $display("FAIL clrwr_busy got %b exp 1", BUSY); else pass_cnt++;
    idle_in();
    for (int c = 0; c < 20 && BUSY === 1'b1; c++) tick();
    total_cnt++; if (BUSY !== 1'b0) $display("FAIL clrwr_timeout got %b exp 0", BUSY); else pass_cnt++;
    ENR = 2'b01; RDA = 6'd0; tick();
    total_cnt++; if (Q[9:0] !== 10'h000) $display("FAIL clrwr_reg0 got %h exp 000", Q[9:0]); else pass_cnt++;
  endtask

  task automatic test_reset_mid_sweep();
    idle_in();
    ENW = 1'b1; WRA = 3'd4; D = 10'h2F0; tick();
    WRA = 3'd7; D = 10'h0F7; tick();
    idle_in();
    CLR = 1'b1; tick();
    CLR = 1'b0; ENR = 2'b11; RDA = {3'd7, 3'd4};
    for (int c = 0; c < 3; c++) tick();
    total_cnt++; if (Q !== {10'h0F7, 10'h2F0}) $display("FAIL pre_rst_q got %h exp %h", Q, {10'h0F7, 10'h2F0}); else pass_cnt++;
    @(posedge CLKb);
    RST = 1'b1;
    #1;
    total_cnt++; if (BUSY !== 1'b0) $display("FAIL midrst_busy got %b exp 0", BUSY); else pass_cnt++;
    total_cnt++; if (Q !== 20'h00000) $display("FAIL midrst_q got %h exp 00000", Q); else pass_cnt++;
    model_reset();
    #1 RST = 1'b0;
    idle_in();
    for (int a = 0; a < 8; a += 2) begin
      ENR = 2'b11; RDA = {3'(a + 1), 3'(a)}; tick();
      total_cnt++; if (Q !== 20'h00000) $display("FAIL postrst_%0d got %h exp 00000", a, Q); else pass_cnt++;
    end
    idle_in();
    ENW = 1'b1; WRA = 3'd4; D = 10'h2DB; tick();
    total_cnt++; if (WDROP !== 1'b0) $display("FAIL postrst_wdrop got %b exp 0", WDROP); else pass_cnt++;
    idle_in();
    ENR = 2'b01; RDA = {3'd0, 3'd4}; tick();
    total_cnt++; if (Q[9:0] !== 10'h2DB) $display("FAIL postrst_wr got %h exp 2db", Q[9:0]); else pass_cnt++;
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      ENW = 1'($urandom_range(0, 1));
      CLR = ($urandom_range(0, 24) == 0);
      ENR = 2'($urandom_range(0, 3));
      RDA = 6'($urandom_range(0, 63));
      WRA = 3'($urandom_range(0, 7));
      D   = 10'($urandom_range(0, 1023));
      tick();
      total_cnt++;
      if (Q !== {m_q[1], m_q[0]} || BUSY !== (m_left > 0) || WDROP !== m_wdrop)
        $display("FAIL rand_%0d got q=%h busy=%b wdrop=%b exp q=%h busy=%b wdrop=%b",
                 n, Q, BUSY, WDROP, {m_q[1], m_q[0]}, (m_left > 0), m_wdrop);
      else pass_cnt++;
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_write_read();
    test_dual_port();
    test_bypass();
    test_clear_sweep();
    test_clr_wr();
    test_reset_mid_sweep();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
